// File: rtl/tcm_ram_pkg.sv
// Shared types and constants for the TCM SRAM port arbiter.
// Requester ids double as bit positions in the one-hot grant vector.
package tcm_ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 64;

endpackage

// File: rtl/tcm_ram_arb_if.sv
// Requester-side bus of the TCM port arbiter: two request channels plus their responses.
// master = requesters (core / loader), slave = arbiter.
interface tcm_ram_arb_if #(
    parameter int ADDR_WIDTH = tcm_ram_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = tcm_ram_pkg::DEF_DATA_WIDTH,
    parameter int NUM_WMASKS = DATA_WIDTH / 8
);
    logic                  a_req_valid_i;
    logic                  a_req_ready_o;
    logic                  a_req_we_i;
    logic [NUM_WMASKS-1:0] a_req_wmask_i;
    logic [ADDR_WIDTH-1:0] a_req_addr_i;
    logic [DATA_WIDTH-1:0] a_req_wdata_i;
    logic                  a_rsp_valid_o;

    logic                  b_req_valid_i;
    logic                  b_req_ready_o;
    logic                  b_req_we_i;
    logic [NUM_WMASKS-1:0] b_req_wmask_i;
    logic [ADDR_WIDTH-1:0] b_req_addr_i;
    logic [DATA_WIDTH-1:0] b_req_wdata_i;
    logic                  b_rsp_valid_o;

    logic [DATA_WIDTH-1:0] rsp_rdata_o;

    modport master (
        output a_req_valid_i, a_req_we_i, a_req_wmask_i, a_req_addr_i, a_req_wdata_i,
        output b_req_valid_i, b_req_we_i, b_req_wmask_i, b_req_addr_i, b_req_wdata_i,
        input  a_req_ready_o, a_rsp_valid_o, b_req_ready_o, b_rsp_valid_o, rsp_rdata_o
    );

    modport slave (
        input  a_req_valid_i, a_req_we_i, a_req_wmask_i, a_req_addr_i, a_req_wdata_i,
        input  b_req_valid_i, b_req_we_i, b_req_wmask_i, b_req_addr_i, b_req_wdata_i,
        output a_req_ready_o, a_rsp_valid_o, b_req_ready_o, b_rsp_valid_o, rsp_rdata_o
    );

endinterface

// File: rtl/tcm_ram_rr_arb.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
// The grant already includes valid, so it doubles as the ready signal.
module tcm_ram_rr_arb
    import tcm_ram_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       valid_a_i,
    input  logic       valid_b_i,
    output logic [1:0] grant_o
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        grant_o      = 2'b00;
        last_grant_d = last_grant_q;
        if (en_i) begin
            if (valid_a_i && (!valid_b_i || last_grant_q == REQ_B)) begin
                grant_o[REQ_A] = 1'b1;
                last_grant_d   = REQ_A;
            end else if (valid_b_i) begin
                grant_o[REQ_B] = 1'b1;
                last_grant_d   = REQ_B;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= REQ_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/tcm_ram_arb.sv
// Zero-fills the TCM SRAM after reset, then shares its read/write port between
// two requesters and returns one response pulse per accepted request.
module tcm_ram_arb
    import tcm_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WMASKS = DATA_WIDTH / 8,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    tcm_ram_arb_if.slave          bus,
    output logic                  init_done_o,
    output logic                  ram_csb_o,
    output logic                  ram_web_o,
    output logic [NUM_WMASKS-1:0] ram_wmask_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_din_o,
    input  logic [DATA_WIDTH-1:0] ram_dout_i
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;

    logic                  run_en;
    logic [1:0]            grant;
    logic                  sel_b;
    logic                  sel_we;
    logic [NUM_WMASKS-1:0] sel_wmask;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  pend_valid_q;
    logic                  pend_owner_q;
    logic                  pend_read_q;
    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    // Reset gates the grant combinationally so nothing is accepted while rst_i is high.
    assign run_en = (state_q == ST_RUN) && !rst_i;

    tcm_ram_rr_arb u_rr_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (run_en),
        .valid_a_i (bus.a_req_valid_i),
        .valid_b_i (bus.b_req_valid_i),
        .grant_o   (grant)
    );

    assign bus.a_req_ready_o = grant[REQ_A];
    assign bus.b_req_ready_o = grant[REQ_B];

    assign sel_b     = grant[REQ_B];
    assign sel_we    = sel_b ? bus.b_req_we_i    : bus.a_req_we_i;
    assign sel_wmask = sel_b ? bus.b_req_wmask_i : bus.a_req_wmask_i;
    assign sel_addr  = sel_b ? bus.b_req_addr_i  : bus.a_req_addr_i;
    assign sel_wdata = sel_b ? bus.b_req_wdata_i : bus.a_req_wdata_i;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == ST_INIT) begin
            init_addr_d = init_addr_q + 1'b1;
            if (init_addr_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT_EN ? ST_INIT : ST_RUN;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    always_comb begin
        ram_csb_o   = 1'b1;
        ram_web_o   = 1'b0;
        ram_wmask_o = '0;
        ram_addr_o  = '0;
        ram_din_o   = '0;
        if (rst_i) begin
            ram_web_o = 1'b1;
        end else if (state_q == ST_INIT) begin
            ram_csb_o   = 1'b0;
            ram_wmask_o = '1;
            ram_addr_o  = init_addr_q;
        end else if (|grant) begin
            ram_csb_o   = 1'b0;
            ram_web_o   = ~sel_we;
            ram_wmask_o = sel_we ? sel_wmask : '0;
            ram_addr_o  = sel_addr;
            ram_din_o   = sel_wdata;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        assign rsp_valid_d[gi] = pend_valid_q && (pend_owner_q == 1'(gi));
    end

    // Stage 1 remembers who was granted; stage 2 fires the pulse once the macro's dout is valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_valid_q <= 1'b0;
            pend_owner_q <= REQ_A;
            pend_read_q  <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= '0;
        end else begin
            pend_valid_q <= |grant;
            pend_owner_q <= sel_b;
            pend_read_q  <= ~sel_we;
            rsp_valid_q  <= rsp_valid_d;
            if (pend_valid_q && pend_read_q) begin
                rsp_rdata_q <= ram_dout_i;
            end
        end
    end

    assign bus.a_rsp_valid_o = rsp_valid_q[REQ_A];
    assign bus.b_rsp_valid_o = rsp_valid_q[REQ_B];
    assign bus.rsp_rdata_o   = rsp_rdata_q;
    assign init_done_o       = (state_q == ST_RUN) && !rst_i;

endmodule

// File: tb/tb_tcm_ram_arb.sv
// Self-checking bench for tcm_ram_arb: behavioural SRAM macro, reference memory and
// per-port response scoreboards with latency tracking.
module tb_tcm_ram_arb;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NW = 8;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic          we;
        logic [NW-1:0] wmask;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic          is_read;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk;
    logic          rst_i;
    logic          init_done_o;
    logic          ram_csb_o;
    logic          ram_web_o;
    logic [NW-1:0] ram_wmask_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_din_o;
    logic [DW-1:0] ram_dout_i;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    req_t qa[$];
    req_t qb[$];
    exp_t exp_a[$];
    exp_t exp_b[$];
    int   grant_log[$];
    logic [DW-1:0] ref_mem [DEPTH];

    tcm_ram_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) bus ();

    tcm_ram_arb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WMASKS (NW),
        .INIT_EN    (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .bus         (bus),
        .init_done_o (init_done_o),
        .ram_csb_o   (ram_csb_o),
        .ram_web_o   (ram_web_o),
        .ram_wmask_o (ram_wmask_o),
        .ram_addr_o  (ram_addr_o),
        .ram_din_o   (ram_din_o),
        .ram_dout_i  (ram_dout_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // SRAM macro model: inputs registered at posedge, array access at the following negedge.
    logic [DW-1:0] sram [DEPTH];
    logic          s_csb, s_web, s_filled;
    logic [NW-1:0] s_wmask;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;

    initial s_filled = 1'b0;

    always @(posedge clk) begin
        s_csb   <= ram_csb_o;
        s_web   <= ram_web_o;
        s_wmask <= ram_wmask_o;
        s_addr  <= ram_addr_o;
        s_din   <= ram_din_o;
    end

    always @(negedge clk) begin
        if (!s_filled) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= {$urandom, $urandom};
            s_filled   <= 1'b1;
            ram_dout_i <= '0;
        end else if (s_csb === 1'b0) begin
            if (s_web === 1'b0) begin
                for (int k = 0; k < NW; k++)
                    if (s_wmask[k]) sram[s_addr][k*8 +: 8] <= s_din[k*8 +: 8];
            end else begin
                ram_dout_i <= sram[s_addr];
            end
        end
    end

    // Response monitor: pops the owner's scoreboard and checks latency and data.
    initial begin
        logic [DW-1:0] last_rdata;
        exp_t e;
        last_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_i) last_rdata = '0;
            if (bus.a_rsp_valid_o === 1'b1 || bus.b_rsp_valid_o === 1'b1) begin
                checks++;
                if (bus.a_rsp_valid_o === 1'b1 && bus.b_rsp_valid_o === 1'b1) begin
                    errors++;
                    $display("FAIL rsp_both: a_rsp_valid_o=1 b_rsp_valid_o=1, required at most one at cycle %0d", cyc_cnt);
                end else if ((bus.a_rsp_valid_o === 1'b1 && exp_a.size() == 0) ||
                             (bus.b_rsp_valid_o === 1'b1 && exp_b.size() == 0)) begin
                    errors++;
                    $display("FAIL rsp_unexpected: a_rsp=%b b_rsp=%b with no pending request at cycle %0d",
                             bus.a_rsp_valid_o, bus.b_rsp_valid_o, cyc_cnt);
                end else begin
                    e = (bus.a_rsp_valid_o === 1'b1) ? exp_a.pop_front() : exp_b.pop_front();
                    if (e.is_read) last_rdata = e.data;
                    if (cyc_cnt != e.due || bus.rsp_rdata_o !== last_rdata) begin
                        errors++;
                        $display("FAIL rsp_%s: cycle=%0d rdata=%h, required cycle=%0d rdata=%h",
                                 (bus.a_rsp_valid_o === 1'b1) ? "a" : "b", cyc_cnt,
                                 bus.rsp_rdata_o, e.due, last_rdata);
                    end else begin
                        $display("rsp %s %s cycle=%0d rdata=%h", (bus.a_rsp_valid_o === 1'b1) ? "A" : "B",
                                 e.is_read ? "read " : "wack ", cyc_cnt, bus.rsp_rdata_o);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic accept(input bit port, input req_t r);
        exp_t e;
        e.due = cyc_cnt + 2;
        if (r.we) begin
            for (int k = 0; k < NW; k++)
                if (r.wmask[k]) ref_mem[r.addr][k*8 +: 8] = r.wdata[k*8 +: 8];
            e.is_read = 1'b0;
            e.data    = '0;
        end else begin
            e.is_read = 1'b1;
            e.data    = ref_mem[r.addr];
        end
        if (port) exp_b.push_back(e);
        else      exp_a.push_back(e);
        grant_log.push_back(int'(port));
        $display("acc %s %s addr=%0d wmask=%h wdata=%h", port ? "B" : "A", r.we ? "write" : "read ",
                 r.addr, r.wmask, r.wdata);
    endtask

    // Presents queue heads on both ports until drained; entered and left at posedge+1.
    task automatic run_reqs(input int budget, output int used);
        bit acc_a, acc_b;
        int d;
        used = 0;
        while ((qa.size() != 0 || qb.size() != 0) && used < budget) begin
            bus.a_req_valid_i = (qa.size() != 0);
            bus.b_req_valid_i = (qb.size() != 0);
            if (qa.size() != 0) begin
                bus.a_req_we_i = qa[0].we; bus.a_req_wmask_i = qa[0].wmask;
                bus.a_req_addr_i = qa[0].addr; bus.a_req_wdata_i = qa[0].wdata;
            end
            if (qb.size() != 0) begin
                bus.b_req_we_i = qb[0].we; bus.b_req_wmask_i = qb[0].wmask;
                bus.b_req_addr_i = qb[0].addr; bus.b_req_wdata_i = qb[0].wdata;
            end
            @(negedge clk);
            checks++;
            if ((bus.a_req_ready_o && bus.b_req_ready_o) ||
                (bus.a_req_ready_o && !bus.a_req_valid_i) || (bus.b_req_ready_o && !bus.b_req_valid_i)) begin
                errors++;
                $display("FAIL ready: a_ready=%b b_ready=%b a_valid=%b b_valid=%b, required one-hot within valid",
                         bus.a_req_ready_o, bus.b_req_ready_o, bus.a_req_valid_i, bus.b_req_valid_i);
            end
            acc_a = bus.a_req_valid_i && bus.a_req_ready_o;
            acc_b = bus.b_req_valid_i && bus.b_req_ready_o;
            if (acc_a) accept(1'b0, qa.pop_front());
            if (acc_b) accept(1'b1, qb.pop_front());
            @(posedge clk);
            #1;
            used++;
        end
        bus.a_req_valid_i = 1'b0;
        bus.b_req_valid_i = 1'b0;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL run_complete: %0d/%0d requests left after %0d cycles, required 0/0",
                     qa.size(), qb.size(), used);
            qa.delete();
            qb.delete();
        end
        d = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && d < 6) begin
            @(negedge clk);
            d++;
        end
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL rsp_missing: %0d/%0d responses outstanding, required 0/0", exp_a.size(), exp_b.size());
            exp_a.delete();
            exp_b.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input bit port, input bit we, input logic [NW-1:0] wmask,
                            input int addr, input logic [DW-1:0] wdata);
        req_t r;
        r.we = we; r.wmask = wmask; r.addr = AW'(addr); r.wdata = wdata;
        if (port) qb.push_back(r);
        else      qa.push_back(r);
    endtask

    // Holds reset with both requesters asking, and checks the reset output values.
    task automatic test_reset(input int hold);
        rst_i = 1'b1;
        bus.a_req_valid_i = 1'b1; bus.a_req_we_i = 1'b0; bus.a_req_wmask_i = '0;
        bus.a_req_addr_i = '0;    bus.a_req_wdata_i = '0;
        bus.b_req_valid_i = 1'b1; bus.b_req_we_i = 1'b0; bus.b_req_wmask_i = '0;
        bus.b_req_addr_i = '0;    bus.b_req_wdata_i = '0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if ({ram_csb_o, ram_web_o, ram_wmask_o, ram_addr_o, ram_din_o, bus.a_req_ready_o,
                 bus.b_req_ready_o, bus.a_rsp_valid_o, bus.b_rsp_valid_o, init_done_o} !==
                {1'b1, 1'b1, 8'h00, 5'd0, 64'h0, 5'b0}) begin
                errors++;
                $display("FAIL reset_outputs: csb=%b web=%b wmask=%h addr=%0d din=%h rdy=%b%b rsp=%b%b done=%b, required 1 1 00 0 0 00 00 0",
                         ram_csb_o, ram_web_o, ram_wmask_o, ram_addr_o, ram_din_o, bus.a_req_ready_o,
                         bus.b_req_ready_o, bus.a_rsp_valid_o, bus.b_rsp_valid_o, init_done_o);
            end
        end
        checks++;
        if (bus.rsp_rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: rsp_rdata_o=%h, required 0", bus.rsp_rdata_o);
        end
        $display("reset held %0d cycles", hold);
        bus.a_req_valid_i = 1'b0;
        bus.b_req_valid_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_init_fill();
        int used;
        rst_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            checks++;
            if ({ram_csb_o, ram_web_o, ram_wmask_o, ram_addr_o, ram_din_o, init_done_o,
                 bus.a_req_ready_o, bus.b_req_ready_o, bus.a_rsp_valid_o, bus.b_rsp_valid_o} !==
                {1'b0, 1'b0, 8'hFF, 5'(i), 64'h0, 5'b0}) begin
                errors++;
                $display("FAIL init_write: csb=%b web=%b wmask=%h addr=%0d din=%h done=%b, required 0 0 ff %0d 0 0",
                         ram_csb_o, ram_web_o, ram_wmask_o, ram_addr_o, ram_din_o, init_done_o, i);
            end
        end
        @(negedge clk);
        checks++;
        if (init_done_o !== 1'b1 || ram_csb_o !== 1'b1) begin
            errors++;
            $display("FAIL init_done: init_done_o=%b csb=%b, required 1 1", init_done_o, ram_csb_o);
        end
        $display("init fill observed, init_done=%b", init_done_o);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(posedge clk);
        #1;
        push_req(1'b0, 1'b0, '0, 0, '0);
        push_req(1'b1, 1'b0, '0, 13, '0);
        push_req(1'b0, 1'b0, '0, 31, '0);
        run_reqs(20, used);
    endtask

    task automatic test_write_read();
        int used;
        push_req(1'b0, 1'b1, 8'hFF, 3, 64'h0123_4567_89AB_CDEF);
        push_req(1'b0, 1'b0, 8'h00, 3, 64'h0);
        run_reqs(20, used);
        checks++;
        if (used != 2) begin
            errors++;
            $display("FAIL write_read_b2b: %0d cycles for 2 requests, required 2", used);
        end
    endtask

    task automatic test_byte_mask();
        int used;
        push_req(1'b1, 1'b1, 8'h0F, 7, 64'hFFFF_FFFF_FFFF_FFFF);
        push_req(1'b1, 1'b0, 8'h00, 7, 64'h0);
        run_reqs(20, used);
        push_req(1'b0, 1'b1, 8'h00, 7, 64'h1234_5678_1234_5678);
        push_req(1'b0, 1'b0, 8'h00, 7, 64'h0);
        push_req(1'b0, 1'b1, 8'hA5, 9, 64'h1122_3344_5566_7788);
        push_req(1'b0, 1'b0, 8'h00, 9, 64'h0);
        run_reqs(20, used);
    endtask

    task automatic test_contention();
        int used;
        for (int i = 1; i <= 8; i++)
            push_req(1'b1, 1'b1, 8'hFF, i, 64'hDEAD_0000_0000_0000 + 64'(i) * 64'h0101_0101);
        run_reqs(30, used);
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            push_req(1'b0, 1'b0, '0, 1 + i, '0);
            push_req(1'b1, 1'b0, '0, 5 + i, '0);
        end
        run_reqs(30, used);
        checks++;
        if (used != 8 || grant_log.size() != 8) begin
            errors++;
            $display("FAIL contention_cycles: %0d cycles %0d grants, required 8 8", used, grant_log.size());
        end
        for (int i = 0; i < grant_log.size(); i++) begin
            checks++;
            if (grant_log[i] != (i % 2)) begin
                errors++;
                $display("FAIL contention_order: grant %0d went to %0d, required %0d", i, grant_log[i], i % 2);
            end
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({ram_csb_o, ram_web_o, ram_wmask_o, ram_addr_o, ram_din_o,
                 bus.a_rsp_valid_o, bus.b_rsp_valid_o} !== {1'b1, 1'b0, 8'h00, 5'd0, 64'h0, 2'b00}) begin
                errors++;
                $display("FAIL idle: csb=%b web=%b wmask=%h addr=%0d din=%h rsp=%b%b, required 1 0 00 0 0 00",
                         ram_csb_o, ram_web_o, ram_wmask_o, ram_addr_o, ram_din_o,
                         bus.a_rsp_valid_o, bus.b_rsp_valid_o);
            end
        end
        $display("idle 10 cycles");
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midflight();
        bus.a_req_valid_i = 1'b1; bus.a_req_we_i = 1'b0; bus.a_req_wmask_i = '0;
        bus.a_req_addr_i = 5'd3;  bus.a_req_wdata_i = '0;
        @(negedge clk);
        checks++;
        if (bus.a_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midflight_accept: a_req_ready_o=%b, required 1", bus.a_req_ready_o);
        end
        $display("midflight read of addr 3 accepted, asserting reset");
        @(posedge clk);
        #1;
        test_reset(3);
        test_init_fill();
    endtask

    initial begin
        rst_i = 1'b1;
        bus.a_req_valid_i = 1'b0;
        bus.b_req_valid_i = 1'b0;
        test_reset(3);
        test_init_fill();
        test_write_read();
        test_byte_mask();
        test_contention();
        test_idle();
        test_reset_midflight();
        test_write_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
